// File: rtl/simon_pkg.sv
// Shared widths, tag type and index helper for the Simon 32/64 pipeline scheduler.
package simon_pkg;

  localparam int SIMON_BLK_W     = 32;
  localparam int SIMON_KEY_W     = 64;
  localparam int SIMON_ROUNDS    = 32;
  localparam int SIMON_MAX_REQ   = 8;
  localparam int SIMON_TAG_ID_W  = $clog2(SIMON_MAX_REQ);

  // Tag id is sized for the largest supported requester count; smaller configs use the low bits.
  typedef struct packed {
    logic                      vld;
    logic [SIMON_TAG_ID_W-1:0] id;
  } simon_tag_t;

  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/simon_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first active request at or after the pointer.
module simon_rr_arb
  import simon_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [ID_W-1:0]    pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic found;

  // Scan offsets from the pointer outward; the first live request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (en && !found && req[i] && (wrap_idx(int'(pointer) + off, NUM_REQ) == i)) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/simon_pipe_sched.sv
// Shares one fixed-latency Simon 32/64 pipeline between NUM_REQ requesters and
// routes every ciphertext back to the requester that issued it, in issue order.
module simon_pipe_sched
  import simon_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int PIPE_LAT = 32,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int CNT_W    = $clog2(PIPE_LAT + 3)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*SIMON_BLK_W-1:0] req_plaintext,
  input  logic [NUM_REQ*SIMON_KEY_W-1:0] req_keytext,
  input  logic                           pause,
  output logic [SIMON_BLK_W-1:0]         pipe_plaintext,
  output logic [SIMON_KEY_W-1:0]         pipe_keytext,
  input  logic [SIMON_BLK_W-1:0]         pipe_ciphertext,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [SIMON_BLK_W-1:0]         rsp_ciphertext,
  output logic [CNT_W-1:0]               inflight,
  output logic                           idle
);

  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_idx;
  logic [ID_W-1:0]        rr_ptr;
  logic                   accept;
  logic                   retire;
  logic [SIMON_BLK_W-1:0] issue_pt;
  logic [SIMON_KEY_W-1:0] issue_key;
  logic [NUM_REQ-1:0]     rsp_hit;
  simon_tag_t             tag_sr [PIPE_LAT+1];
  simon_tag_t             tag_out;

  simon_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .en        (!pause),
    .pointer   (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign retire    = |rsp_valid;
  assign idle      = (inflight == '0);

  // Data of the granted requester, zero when nothing is granted so idle slots feed zeros.
  always_comb begin
    issue_pt  = '0;
    issue_key = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        issue_pt  = req_plaintext[i*SIMON_BLK_W +: SIMON_BLK_W];
        issue_key = req_keytext[i*SIMON_KEY_W +: SIMON_KEY_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr         <= '0;
      pipe_plaintext <= '0;
      pipe_keytext   <= '0;
    end else begin
      pipe_plaintext <= issue_pt;
      pipe_keytext   <= issue_key;
      if (accept) begin
        rr_ptr <= ID_W'(wrap_idx(int'(grant_idx) + 1, NUM_REQ));
      end
    end
  end

  // Stage 0 sits beside the pipe input registers; PIPE_LAT further stages line the tag up with pipe_ciphertext.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= PIPE_LAT; s++) begin
        tag_sr[s] <= '0;
      end
    end else begin
      tag_sr[0].vld <= accept;
      tag_sr[0].id  <= SIMON_TAG_ID_W'(grant_idx);
      for (int s = 1; s <= PIPE_LAT; s++) begin
        tag_sr[s] <= tag_sr[s-1];
      end
    end
  end

  assign tag_out = tag_sr[PIPE_LAT];

  always_comb begin
    rsp_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_hit[i] = tag_out.vld && (tag_out.id == SIMON_TAG_ID_W'(i));
    end
  end

  // Clearing the tags on reset is what drops pre-reset results still inside the un-reset pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid      <= '0;
      rsp_ciphertext <= '0;
    end else begin
      rsp_valid <= rsp_hit;
      if (tag_out.vld) begin
        rsp_ciphertext <= pipe_ciphertext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (accept && !retire) begin
      inflight <= inflight + CNT_W'(1);
    end else if (!accept && retire) begin
      inflight <= inflight - CNT_W'(1);
    end
  end

endmodule
